// File: rtl/frame_sched_pkg.sv
// Shared types and default widths for the frame bank scheduler and its
// capture/display front-ends.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_SWAP = 2'd3
  } fbs_state_e;

  typedef logic bank_t;

  localparam int unsigned FBS_ADDR_W = 16;
  localparam int unsigned FBS_DATA_W = 16;

endpackage

// File: rtl/vsync_edge_detect.sv
// One-cycle pulse on the transition of the filtered VSYNC into its active level.
module vsync_edge_detect #(
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync_in,
  output logic vsync_edge
);

  logic vsync_prev_q;

  always_ff @(posedge clk) begin
    if (reset) vsync_prev_q <= ~VSYNC_ACTIVE;
    else       vsync_prev_q <= vsync_in;
  end

  assign vsync_edge = (vsync_in == VSYNC_ACTIVE) && (vsync_prev_q != VSYNC_ACTIVE);

endmodule

// File: rtl/frame_bank_scheduler.sv
// Arbitrates the single frame-memory port between capture writes and display reads,
// double-buffering two banks swapped on VSYNC. Optional mem_ack timeout: FBS_TIMEOUT_EN.
module frame_bank_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned ADDR_W       = FBS_ADDR_W,
  parameter int unsigned DATA_W       = FBS_DATA_W,
  parameter logic        VSYNC_ACTIVE = 1'b0,
  parameter int unsigned MAX_RD_BURST = 4,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_bank,
  output logic              swap_overrun,
  output logic              mem_err
);

  localparam int unsigned STREAK_W = 4;

  if (MAX_RD_BURST < 1 || MAX_RD_BURST > 15 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("frame_bank_scheduler: parameter out of range");
  end

  fbs_state_e          state_q, state_d;
  bank_t               disp_bank_q, disp_bank_d;
  logic [STREAK_W-1:0] rd_streak_q, rd_streak_d;
  logic                swap_pending_q, swap_pending_d;
  logic                swap_overrun_q, swap_overrun_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                swap_clr;
  logic                vsync_edge;
  logic                xfer_abort;
  logic                in_xfer;

  vsync_edge_detect #(.VSYNC_ACTIVE(VSYNC_ACTIVE)) u_vsync_edge (
    .clk        (clk),
    .reset      (reset),
    .vsync_in   (vsync_in),
    .vsync_edge (vsync_edge)
  );

  assign in_xfer = (state_q == ST_WR) || (state_q == ST_RD);

`ifdef FBS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            mem_err_q;

  // Counter holds the number of elapsed WR/RD cycles; abort ends the TIMEOUT_CYC-th one.
  assign xfer_abort = in_xfer && !mem_ack && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      to_cnt_q <= in_xfer ? to_cnt_q + 1'b1 : '0;
      if (xfer_abort) mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign xfer_abort = 1'b0;
  assign mem_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    rd_streak_d = rd_streak_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    rd_data_d   = rd_data_q;
    swap_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (swap_pending_q) begin
          state_d = ST_SWAP;
        end else if (rd_req && (!wr_req || rd_streak_q < STREAK_W'(MAX_RD_BURST))) begin
          state_d     = ST_RD;
          mem_we_d    = 1'b0;
          mem_addr_d  = {disp_bank_q, rd_addr};
          rd_streak_d = wr_req ? rd_streak_q + 4'd1 : '0;
        end else if (wr_req) begin
          state_d     = ST_WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = {~disp_bank_q, wr_addr};
          mem_wdata_d = wr_data;
          rd_streak_d = '0;
        end
      end
      ST_WR, ST_RD: begin
        if (mem_ack || xfer_abort) begin
          state_d = ST_IDLE;
          if (state_q == ST_WR) begin
            wr_ack_d = 1'b1;
          end else begin
            rd_ack_d = 1'b1;
            if (mem_ack) rd_data_d = mem_rdata;
          end
        end
      end
      ST_SWAP: begin
        disp_bank_d = ~disp_bank_q;
        rd_streak_d = '0;
        swap_clr    = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge in the swap cycle re-arms the swap rather than counting as an overrun.
    swap_pending_d = vsync_edge | (swap_pending_q & ~swap_clr);
    swap_overrun_d = swap_overrun_q | (vsync_edge & swap_pending_q & ~swap_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      disp_bank_q    <= 1'b0;
      rd_streak_q    <= '0;
      swap_pending_q <= 1'b0;
      swap_overrun_q <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      disp_bank_q    <= disp_bank_d;
      rd_streak_q    <= rd_streak_d;
      swap_pending_q <= swap_pending_d;
      swap_overrun_q <= swap_overrun_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      wr_ack_q       <= wr_ack_d;
      rd_ack_q       <= rd_ack_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign mem_req      = in_xfer;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign wr_ack       = wr_ack_q;
  assign rd_ack       = rd_ack_q;
  assign rd_data      = rd_data_q;
  assign disp_bank    = disp_bank_q;
  assign swap_overrun = swap_overrun_q;

endmodule
